// File: rtl/addecrc_pad_if.sv
// Nibble stream bus between the MAC framer, the pad/FCS stage and the preamble inserter.
// Latency: none (wires only).
// Backpressure: o_busy tells the source to hold i_v low while padding or appending the FCS.
interface addecrc_pad_if;
  logic       i_ce;
  logic       i_en;
  logic       i_cancel;
  logic       i_v;
  logic [3:0] i_d;
  logic       o_v;
  logic [3:0] o_d;
  logic       o_busy;

  modport master (
    output i_ce, i_en, i_cancel, i_v, i_d,
    input  o_v, o_d, o_busy
  );

  modport slave (
    input  i_ce, i_en, i_cancel, i_v, i_d,
    output o_v, o_d, o_busy
  );
endinterface

// File: rtl/addecrc_pad.sv
// Zero-pads short Ethernet frames to MIN_NIBBLES and appends the 32-bit FCS, low nibble first.
// Latency: one i_ce from each input nibble to its output nibble; output is gap-free through the FCS.
// Backpressure: o_busy is high during PAD/FCS; input nibbles arriving then are ignored.
module addecrc_pad #(
  parameter int MIN_NIBBLES = 120,
  parameter int CW          = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  addecrc_pad_if.slave bus
);

  localparam logic [31:0]   POLY     = 32'hEDB88320;
  localparam logic [31:0]   CRC_INIT = 32'hFFFFFFFF;
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_NIBBLES);

  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

  state_t        state_q, state_d;
  logic [31:0]   crc_q, crc_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    fcnt_q, fcnt_d;
  logic          en_q, en_d;
  logic          o_v_q, o_v_d;
  logic [3:0]    o_d_q, o_d_d;
  logic          busy_q, busy_d;

  logic [31:0]   fcs_w;
  logic [31:0]   fcs_sh;
  logic [3:0]    fcs_nib;
  logic [CW-1:0] count_inc;

  // Four LSB-first steps of the reflected CRC-32 for one nibble.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 4; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  // FCS nibble selection and the saturating frame-length counter.
  always_comb begin
    fcs_w     = ~crc_q;
    fcs_sh    = fcs_w >> {fcnt_q[2:0], 2'b00};
    fcs_nib   = fcs_sh[3:0];
    count_inc = (count_q < MIN_C) ? count_q + 1'b1 : count_q;
  end

  // Next-state and next-output logic; everything holds unless i_ce is high.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    count_d = count_q;
    fcnt_d  = fcnt_q;
    en_d    = en_q;
    o_v_d   = o_v_q;
    o_d_d   = o_d_q;
    busy_d  = busy_q;

    if (bus.i_ce) begin
      if (bus.i_cancel) begin
        // Abort wins over any incoming nibble; drop straight back to idle.
        state_d = IDLE;
        crc_d   = CRC_INIT;
        count_d = '0;
        fcnt_d  = '0;
        en_d    = 1'b0;
        o_v_d   = 1'b0;
        o_d_d   = 4'h0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.i_v) begin
              en_d    = bus.i_en;
              o_v_d   = 1'b1;
              o_d_d   = bus.i_d;
              crc_d   = crc_nib(CRC_INIT, bus.i_d);
              count_d = (MIN_C != '0) ? CW'(1) : '0;
              state_d = DATA;
            end else begin
              o_v_d = 1'b0;
              o_d_d = 4'h0;
            end
          end

          DATA: begin
            if (bus.i_v) begin
              o_v_d   = 1'b1;
              o_d_d   = bus.i_d;
              crc_d   = crc_nib(crc_q, bus.i_d);
              count_d = count_inc;
            end else if (!en_q) begin
              // Pass-through frame: no pad, no FCS.
              o_v_d   = 1'b0;
              o_d_d   = 4'h0;
              crc_d   = CRC_INIT;
              count_d = '0;
              state_d = IDLE;
            end else if (count_q < MIN_C) begin
              o_v_d   = 1'b1;
              o_d_d   = 4'h0;
              crc_d   = crc_nib(crc_q, 4'h0);
              count_d = count_inc;
              state_d = PAD;
            end else begin
              o_v_d   = 1'b1;
              o_d_d   = fcs_w[3:0];
              fcnt_d  = 4'd1;
              state_d = FCS;
            end
          end

          PAD: begin
            if (count_q < MIN_C) begin
              o_v_d   = 1'b1;
              o_d_d   = 4'h0;
              crc_d   = crc_nib(crc_q, 4'h0);
              count_d = count_inc;
            end else begin
              // Minimum reached: first FCS nibble follows the last pad with no gap.
              o_v_d   = 1'b1;
              o_d_d   = fcs_w[3:0];
              fcnt_d  = 4'd1;
              state_d = FCS;
            end
          end

          FCS: begin
            if (fcnt_q == 4'd8) begin
              o_v_d   = 1'b0;
              o_d_d   = 4'h0;
              crc_d   = CRC_INIT;
              count_d = '0;
              fcnt_d  = '0;
              state_d = IDLE;
            end else begin
              o_v_d  = 1'b1;
              o_d_d  = fcs_nib;
              fcnt_d = fcnt_q + 4'd1;
            end
          end

          default: state_d = IDLE;
        endcase
      end
      busy_d = (state_d == PAD) || (state_d == FCS);
    end
  end

  // State and registered outputs; reset clears the packet without emitting a partial FCS.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      count_q <= '0;
      fcnt_q  <= '0;
      en_q    <= 1'b0;
      o_v_q   <= 1'b0;
      o_d_q   <= 4'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      count_q <= count_d;
      fcnt_q  <= fcnt_d;
      en_q    <= en_d;
      o_v_q   <= o_v_d;
      o_d_q   <= o_d_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_v    = o_v_q;
  assign bus.o_d    = o_d_q;
  assign bus.o_busy = busy_q;

endmodule

// File: tb/tb_addecrc_pad.sv
// Directed bench for addecrc_pad: one instance without padding, one with the default minimum.
// Both instances see the same stimulus; outputs are captured on every i_ce cycle.
// Expected FCS values come from constants and an independent bitwise CRC-32 reference.
module tb_addecrc_pad;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce, en, cancel, v;
  logic [3:0] d;

  addecrc_pad_if ifa ();
  addecrc_pad_if ifb ();

  assign ifa.i_ce = ce;  assign ifa.i_en = en;  assign ifa.i_cancel = cancel;
  assign ifa.i_v  = v;   assign ifa.i_d  = d;
  assign ifb.i_ce = ce;  assign ifb.i_en = en;  assign ifb.i_cancel = cancel;
  assign ifb.i_v  = v;   assign ifb.i_d  = d;

  addecrc_pad #(.MIN_NIBBLES(0)) dut0 (.i_clk(clk), .i_reset(rst), .bus(ifa));
  addecrc_pad                    dut  (.i_clk(clk), .i_reset(rst), .bus(ifb));

  always #5 clk = ~clk;

  int         ntot = 0, npass = 0, nfail = 0;
  logic [3:0] fr[$];
  logic [3:0] q0[$], q1[$];
  int         cidx = 0, first1 = -1, last1 = -1, hold_err = 0, c_start;
  logic       busy1 = 1'b0, pv = 1'b0;
  logic [3:0] pd = 4'h0;
  string      s;
  logic       ov_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick(input logic ce_in);
    ce = ce_in;
    @(posedge clk);
    #1;
    if (ce_in) begin
      cidx++;
      if (ifa.o_v) q0.push_back(ifa.o_d);
      if (ifb.o_v) begin
        q1.push_back(ifb.o_d);
        if (first1 < 0) first1 = cidx;
        last1 = cidx;
      end
      if (ifb.o_busy) busy1 = 1'b1;
    end else if (ifb.o_v !== pv || ifb.o_d !== pd) begin
      hold_err++;
    end
    pv = ifb.o_v;
    pd = ifb.o_d;
  endtask

  task automatic pulse(input int div);
    for (int j = 1; j < div; j++) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic clear();
    q0.delete(); q1.delete();
    first1 = -1; last1 = -1; busy1 = 1'b0; hold_err = 0;
  endtask

  // Send fr with i_ce every div clocks, then idle long enough for pad + FCS.
  task automatic send(input logic en_in, input int div);
    en = en_in;
    foreach (fr[i]) begin
      v = 1'b1; d = fr[i];
      pulse(div);
    end
    v = 1'b0; d = 4'h0;
    for (int k = 0; k < 115; k++) pulse(div);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 4; b++) begin
      fb = r[0] ^ n[b];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_fcs(input int min);
    logic [31:0] c;
    int          cnt;
    c = 32'hFFFFFFFF;
    cnt = 0;
    foreach (fr[i]) begin c = crc_step(c, fr[i]); cnt++; end
    while (cnt < min) begin c = crc_step(c, 4'h0); cnt++; end
    return ~c;
  endfunction

  function automatic logic [31:0] fcs_of(input logic [3:0] q[$]);
    logic [31:0] r;
    r = 32'h0;
    if (q.size() >= 8)
      for (int k = 0; k < 8; k++) r[4*k +: 4] = q[q.size() - 8 + k];
    return r;
  endfunction

  // Mismatches of data echo plus non-zero pad nibbles (pad = everything before the last 8).
  function automatic int body_err(input logic [3:0] q[$], input logic has_fcs);
    int e;
    int stop;
    e = 0;
    foreach (fr[i]) if (i >= q.size() || q[i] !== fr[i]) e++;
    stop = has_fcs ? q.size() - 8 : q.size();
    for (int i = fr.size(); i < stop; i++) if (q[i] !== 4'h0) e++;
    return e;
  endfunction

  initial begin
    rst = 1'b1; ce = 1'b0; en = 1'b0; cancel = 1'b0; v = 1'b0; d = 4'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_v", 32'(ifb.o_v), 32'd0);
    chk("rst_o_d", 32'(ifb.o_d), 32'd0);
    chk("rst_o_busy", 32'(ifb.o_busy), 32'd0);
    chk("rst_o_v_nopad", 32'(ifa.o_v), 32'd0);
    rst = 1'b0;
    tick(1'b1);

    // Check value "123456789", no padding instance
    clear();
    s = "123456789";
    fr.delete();
    for (int i = 0; i < 9; i++) begin
      fr.push_back(s[i][3:0]);
      fr.push_back(s[i][7:4]);
    end
    c_start = cidx;
    send(1'b1, 1);
    chk("t1_len", 32'(q0.size()), 32'd26);
    chk("t1_data", 32'(body_err(q0, 1'b1)), 32'd0);
    chk("t1_fcs", fcs_of(q0), 32'hCBF43926);
    chk("t1_end_o_v", 32'(ifa.o_v), 32'd0);
    chk("t1_latency", 32'(first1), 32'(c_start + 1));
    chk("t1_padded_len", 32'(q1.size()), 32'd128);

    // 28-nibble frame padded to 120
    clear();
    fr.delete();
    for (int i = 0; i < 28; i++) fr.push_back(4'(i * 7 + 3));
    send(1'b1, 1);
    chk("t2_len", 32'(q1.size()), 32'd128);
    chk("t2_contig", 32'(last1 - first1 + 1), 32'(q1.size()));
    chk("t2_data_pad", 32'(body_err(q1, 1'b1)), 32'd0);
    chk("t2_fcs", fcs_of(q1), exp_fcs(120));
    chk("t2_busy_seen", 32'(busy1), 32'd1);

    // 64-byte frame with i_ce one cycle in three
    clear();
    fr.delete();
    for (int i = 0; i < 128; i++) fr.push_back(4'(i * 5 + 1));
    c_start = cidx;
    send(1'b1, 3);
    chk("t3_len", 32'(q1.size()), 32'd136);
    chk("t3_contig", 32'(last1 - first1 + 1), 32'(q1.size()));
    chk("t3_latency", 32'(first1), 32'(c_start + 1));
    chk("t3_hold_no_ce", 32'(hold_err), 32'd0);
    chk("t3_data", 32'(body_err(q1, 1'b1)), 32'd0);
    chk("t3_fcs", fcs_of(q1), exp_fcs(120));

    // Pass-through, i_en low
    clear();
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(4'(i + 6));
    send(1'b0, 1);
    chk("t4_len", 32'(q1.size()), 32'd10);
    chk("t4_data", 32'(body_err(q1, 1'b0)), 32'd0);
    chk("t4_busy_never", 32'(busy1), 32'd0);
    chk("t4_len_nopad", 32'(q0.size()), 32'd10);

    // Cancel while the 3rd FCS nibble is on the output
    clear();
    fr.delete();
    for (int i = 0; i < 120; i++) fr.push_back(4'(i * 3));
    en = 1'b1;
    foreach (fr[i]) begin
      v = 1'b1; d = fr[i];
      tick(1'b1);
    end
    v = 1'b0; d = 4'h0;
    repeat (3) tick(1'b1);
    chk("t5_pre_cancel_len", 32'(q1.size()), 32'd123);
    cancel = 1'b1;
    tick(1'b1);
    cancel = 1'b0;
    chk("t5_cancel_o_v", 32'(ifb.o_v), 32'd0);
    chk("t5_cancel_busy", 32'(ifb.o_busy), 32'd0);
    repeat (3) tick(1'b1);
    clear();
    fr.delete();
    for (int i = 0; i < 20; i++) fr.push_back(4'(i * 11 + 2));
    send(1'b1, 1);
    chk("t5_next_len", 32'(q1.size()), 32'd128);
    chk("t5_next_fcs", fcs_of(q1), exp_fcs(120));

    // Asynchronous reset in the middle of DATA
    clear();
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(4'(i + 1));
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = 1'b1; d = fr[i];
      tick(1'b1);
    end
    ov_before = ifb.o_v;
    chk("t6_o_v_before", 32'(ov_before), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_o_v", 32'(ifb.o_v), 32'd0);
    chk("t6_async_o_d", 32'(ifb.o_d), 32'd0);
    chk("t6_async_busy", 32'(ifb.o_busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    v = 1'b0; d = 4'h0;
    tick(1'b1);
    clear();
    fr.delete();
    for (int i = 0; i < 16; i++) fr.push_back(4'(15 - i));
    send(1'b1, 1);
    chk("t6_new_len", 32'(q1.size()), 32'd128);
    chk("t6_new_fcs", fcs_of(q1), exp_fcs(120));
    chk("t6_new_fcs_nopad", fcs_of(q0), exp_fcs(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
